// File: rtl/serial_a_paralelo_pkg.sv
// Shared constants and state encoding for the serial link receiver.
package serial_a_paralelo_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_a_paralelo_comma_detector.sv
// Serial shift register (MSB first) plus the comma compare on its contents.
module serial_a_paralelo_comma_detector
    import serial_a_paralelo_pkg::*;
(
    input  logic              clk32f,
    input  logic              reset,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] sr,
    output logic              is_comma
);

    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[BYTE_W-2:0], serial_in};
        end
    end

    // Compare is taken from the register, so no serial_in-to-output path exists.
    assign is_comma = (sr == COMMA);

endmodule

// File: rtl/serial_a_paralelo.sv
// Serial-to-parallel receiver: comma alignment, lock counting and byte delivery.
// Optional macro RX_BC_CNT_EN adds a saturating count of idle commas seen while active.
module serial_a_paralelo
    import serial_a_paralelo_pkg::*;
#(
    parameter int BC_LOCK = 4
) (
    input  logic              clk32f,
    input  logic              reset,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
`ifdef RX_BC_CNT_EN
    ,
    output logic [7:0]        bc_count
`endif
);

    localparam logic [2:0] LOCK_TARGET = 3'(BC_LOCK);

    logic [BYTE_W-1:0] sr;
    logic              is_comma;

    rx_state_t         state, state_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [2:0]        bc_cnt, bc_cnt_n;
    logic [2:0]        bc_inc;
    logic              boundary;
    logic [BYTE_W-1:0] data_n;
    logic              valid_n;
    logic              active_n;
`ifdef RX_BC_CNT_EN
    logic [7:0]        bc_count_n;
`endif

    serial_a_paralelo_comma_detector u_comma_detector (
        .clk32f    (clk32f),
        .reset     (reset),
        .serial_in (serial_in),
        .sr        (sr),
        .is_comma  (is_comma)
    );

    assign boundary = (bit_cnt == 3'd7);
    assign bc_inc   = bc_cnt + 3'd1;

    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            bit_cnt   <= '0;
            bc_cnt    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
`ifdef RX_BC_CNT_EN
            bc_count  <= '0;
`endif
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            bc_cnt    <= bc_cnt_n;
            data_out  <= data_n;
            valid_out <= valid_n;
            active    <= active_n;
`ifdef RX_BC_CNT_EN
            bc_count  <= bc_count_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bc_cnt_n  = bc_cnt;
        data_n    = data_out;
        valid_n   = 1'b0;
        active_n  = active;
`ifdef RX_BC_CNT_EN
        bc_count_n = bc_count;
`endif
        case (state)
            SEARCH: begin
                // Any bit offset may hold the comma; its end defines the byte grid.
                if (is_comma) begin
                    bit_cnt_n = '0;
                    bc_cnt_n  = 3'd1;
                    state_n   = LOCK;
                end
            end
            LOCK: begin
                bit_cnt_n = bit_cnt + 3'd1;
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_n = bc_inc;
                        if (bc_inc == LOCK_TARGET) begin
                            state_n  = ACTIVE;
                            active_n = 1'b1;
                        end
                    end else begin
                        bc_cnt_n = '0;
                        state_n  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_n = bit_cnt + 3'd1;
                if (boundary) begin
                    if (!is_comma) begin
                        data_n  = sr;
                        valid_n = 1'b1;
                    end
`ifdef RX_BC_CNT_EN
                    else if (bc_count != 8'hFF) begin
                        bc_count_n = bc_count + 8'd1;
                    end
`endif
                end
            end
            default: begin
                state_n = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_a_paralelo.sv
// Bench for serial_a_paralelo: random and directed bit streams against a bit-index reference model.
module tb_serial_a_paralelo;

    localparam int BC_LOCK = 4;
`ifdef RX_BC_CNT_EN
    localparam logic [17:0] CMP_MASK = 18'h3FFFF;
`else
    localparam logic [17:0] CMP_MASK = 18'h003FF;
`endif

    logic       clk32f;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [7:0] bc_view;
`ifdef RX_BC_CNT_EN
    logic [7:0] bc_count;
    assign bc_view = bc_count;
`else
    assign bc_view = 8'd0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic        bits_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] act_q[$];

    serial_a_paralelo #(.BC_LOCK(BC_LOCK)) dut (
        .clk32f    (clk32f),
        .reset     (reset),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
`ifdef RX_BC_CNT_EN
        ,
        .bc_count  (bc_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk32f = 1'b0;
    always #5 clk32f = ~clk32f;

    task automatic apply_reset();
        reset     = 1'b1;
        serial_in = 1'b0;
        repeat (2) @(posedge clk32f);
        #1 reset = 1'b0;
    endtask

    // ---------------- stream building ----------------
    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bits_q.push_back(b[i]);
    endtask

    task automatic push_commas(input int n);
        for (int i = 0; i < n; i++) push_byte(8'hBC);
    endtask

    task automatic push_junk(input int n);
        for (int i = 0; i < n; i++) bits_q.push_back(1'($urandom_range(0, 1)));
    endtask

    // Byte formed by the 8 bits ending at index e; bits before the stream count as 0.
    function automatic logic [7:0] win(input int e);
        logic [7:0] w = '0;
        for (int b = 0; b < 8; b++) begin
            int idx = e - 7 + b;
            w = {w[6:0], (idx >= 0 && idx < bits_q.size()) ? bits_q[idx] : 1'b0};
        end
        return w;
    endfunction

    // Reference: scan bit positions for a comma, then walk whole bytes from it.
    // An effect of the byte ending at bit index d is visible after edge d+1.
    task automatic build_expect();
        int n = bits_q.size();
        bit ev_valid[];
        bit ev_bc[];
        logic [7:0] ev_data[];
        int lock_cycle = n + 1;
        int e = 0;
        int end_i, cnt;
        bit done, locked;
        logic [7:0] cur_data = '0;
        int bc = 0;
        ev_valid = new[n];
        ev_bc    = new[n];
        ev_data  = new[n];
        locked = 0;
        end_i = 0;
        while (e < n && !locked) begin
            if (win(e) == 8'hBC) begin
                end_i = e;
                cnt = 1;
                done = 0;
                while (!done) begin
                    end_i += 8;
                    if (end_i >= n) begin
                        e = n;
                        done = 1;
                    end else if (win(end_i) != 8'hBC) begin
                        e = end_i + 1;
                        done = 1;
                    end else begin
                        cnt++;
                        if (cnt == BC_LOCK) begin
                            lock_cycle = end_i + 1;
                            locked = 1;
                            done = 1;
                        end
                    end
                end
            end else begin
                e++;
            end
        end
        if (locked) begin
            for (int d = end_i + 8; d + 1 < n; d += 8) begin
                if (win(d) != 8'hBC) begin
                    ev_valid[d+1] = 1'b1;
                    ev_data[d+1]  = win(d);
                end else begin
                    ev_bc[d+1] = 1'b1;
                end
            end
        end
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            if (ev_valid[c]) cur_data = ev_data[c];
            if (ev_bc[c] && bc < 255) bc++;
            exp_q.push_back({8'(bc), (c >= lock_cycle), ev_valid[c], cur_data});
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_stream();
        build_expect();
        act_q.delete();
        for (int i = 0; i < bits_q.size(); i++) begin
            serial_in = bits_q[i];
            @(posedge clk32f);
            #1 act_q.push_back({bc_view, active, valid_out, data_out});
        end
        bits_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        serial_in = 1'b0;
        #1;
        n_vec++;
        if ({bc_view, active, valid_out, data_out} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_initial got=%h exp=%h", {bc_view, active, valid_out, data_out}, 18'd0);
        end
        apply_reset();
        push_commas(4); push_byte(8'h5A); push_byte(8'h3C); push_byte(8'h77);
        push_junk(3);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if ((act_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
                n_err++;
                $display("FAIL reset_prelock cyc=%0d got=%h exp=%h", i, act_q[i], exp_q[i]);
            end
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({bc_view, active, valid_out, data_out} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_async got=%h exp=%h", {bc_view, active, valid_out, data_out}, 18'd0);
        end
        @(posedge clk32f);
        #1 reset = 1'b0;
        push_commas(4); push_byte(8'h33); push_byte(8'hBC);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if ((act_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
                n_err++;
                $display("FAIL reset_relock cyc=%0d got=%h exp=%h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_lock_data();
        apply_reset();
        push_commas(4); push_byte(8'h5A); push_byte(8'h3C); push_commas(2);
        run_stream();
        // Hand-derived: active after edge 32, pulses after edges 40 and 48.
        n_vec++;
        if (act_q[31][9] !== 1'b0 || act_q[32][9] !== 1'b1 ||
            act_q[40][8:0] !== 9'h15A || act_q[48][8:0] !== 9'h13C) begin
            n_err++;
            $display("FAIL lock_data_fixed got31=%h got32=%h got40=%h got48=%h",
                     act_q[31], act_q[32], act_q[40], act_q[48]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if ((act_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
                n_err++;
                $display("FAIL lock_data cyc=%0d got=%h exp=%h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_failed_lock();
        apply_reset();
        push_commas(3); push_byte(8'h00); push_commas(4); push_byte(8'hA5); push_commas(1);
        run_stream();
        n_vec++;
        if (act_q[40][9] !== 1'b0 || act_q[72][8:0] !== 9'h1A5) begin
            n_err++;
            $display("FAIL failed_lock_fixed got40=%h got72=%h exp active=0 then 1a5", act_q[40], act_q[72]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if ((act_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
                n_err++;
                $display("FAIL failed_lock cyc=%0d got=%h exp=%h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_bit_offset();
        for (int off = 0; off < 8; off++) begin
            apply_reset();
            if (off == 3) begin
                bits_q.push_back(1'b1); bits_q.push_back(1'b0); bits_q.push_back(1'b1);
            end else begin
                push_junk(off);
            end
            push_commas(4); push_byte(8'h81); push_commas(1);
            run_stream();
            n_vec++;
            if (act_q[off + 40][8:0] !== 9'h181) begin
                n_err++;
                $display("FAIL bit_offset_%0d got=%h exp=181", off, act_q[off + 40][8:0]);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if ((act_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
                    n_err++;
                    $display("FAIL bit_offset_%0d cyc=%0d got=%h exp=%h", off, i, act_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_comma_in_data();
        apply_reset();
        push_commas(4); push_byte(8'hA5); push_byte(8'hBC); push_byte(8'h11); push_commas(1);
        run_stream();
        n_vec++;
        if (act_q[40][8:0] !== 9'h1A5 || act_q[48][8:0] !== 9'h0A5 || act_q[56][8:0] !== 9'h111) begin
            n_err++;
            $display("FAIL comma_in_data_fixed got40=%h got48=%h got56=%h exp 1a5 0a5 111",
                     act_q[40][8:0], act_q[48][8:0], act_q[56][8:0]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if ((act_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
                n_err++;
                $display("FAIL comma_in_data cyc=%0d got=%h exp=%h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            apply_reset();
            push_junk($urandom_range(0, 15));
            push_commas($urandom_range(1, 5));
            if ($urandom_range(0, 1) == 1) begin
                push_byte(8'($urandom_range(0, 255)));
                push_commas($urandom_range(2, 5));
            end
            for (int b = 0; b < 10; b++) begin
                if ($urandom_range(0, 3) == 0) push_byte(8'hBC);
                else push_byte(8'($urandom_range(0, 255)));
            end
            run_stream();
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if ((act_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
                    n_err++;
                    $display("FAIL random_%0d cyc=%0d got=%h exp=%h", it, i, act_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_bc_saturate();
        apply_reset();
        push_commas(4); push_commas(300); push_byte(8'h42); push_commas(2);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if ((act_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
                n_err++;
                $display("FAIL bc_saturate cyc=%0d got=%h exp=%h", i, act_q[i], exp_q[i]);
            end
        end
`ifdef RX_BC_CNT_EN
        n_vec++;
        if (bc_count !== 8'd255) begin
            n_err++;
            $display("FAIL bc_saturate_final got=%0d exp=255", bc_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lock_data();
        test_failed_lock();
        test_bit_offset();
        test_comma_in_data();
        test_random();
        test_bc_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
